// File: rtl/idexe_pipe_hz_if.sv
// ID/EXE stage bundle: decode-side inputs, execute-side registered outputs,
// and the combinational load-use hazard back to IF/ID.
interface idexe_pipe_hz_if #(
  parameter int ARQ        = 16,
  parameter int JADDR_W    = 13,
  parameter int ALU_OP_W   = 2,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 8
);
  logic                  stall_in, flush_in, valid_in;
  logic                  wb_enable_in, mem_enable_in, mux_exe_in, jop_lsb_in;
  logic [ARQ-1:0]        src1_in, src2_in, srcdest_in, imm_in;
  logic [ALU_OP_W-1:0]   alu_op_in;
  logic [JADDR_W-1:0]    jaddr_in;
  logic [REG_ADDR_W-1:0] rs1_addr_in, rs2_addr_in, rd_addr_in;

  logic                  valid_out;
  logic                  wb_enable_out, mem_enable_out, mux_exe_out, jop_lsb_out;
  logic [ARQ-1:0]        src1_out, src2_out, srcdest_out, imm_out;
  logic [ALU_OP_W-1:0]   alu_op_out;
  logic [JADDR_W-1:0]    jaddr_out;
  logic [REG_ADDR_W-1:0] rd_addr_out;
  logic                  hazard_out;
  logic [CNT_W-1:0]      bubble_cnt_out;

  modport master (
    output stall_in, flush_in, valid_in,
           wb_enable_in, mem_enable_in, mux_exe_in, jop_lsb_in,
           src1_in, src2_in, srcdest_in, imm_in, alu_op_in, jaddr_in,
           rs1_addr_in, rs2_addr_in, rd_addr_in,
    input  valid_out, wb_enable_out, mem_enable_out, mux_exe_out, jop_lsb_out,
           src1_out, src2_out, srcdest_out, imm_out, alu_op_out, jaddr_out,
           rd_addr_out, hazard_out, bubble_cnt_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in,
           wb_enable_in, mem_enable_in, mux_exe_in, jop_lsb_in,
           src1_in, src2_in, srcdest_in, imm_in, alu_op_in, jaddr_in,
           rs1_addr_in, rs2_addr_in, rd_addr_in,
    output valid_out, wb_enable_out, mem_enable_out, mux_exe_out, jop_lsb_out,
           src1_out, src2_out, srcdest_out, imm_out, alu_op_out, jaddr_out,
           rd_addr_out, hazard_out, bubble_cnt_out
  );
endinterface

// File: rtl/idexe_pipe_hz.sv
// ID/EXE pipeline register with valid, stall, flush, load-use bubble
// insertion and a saturating bubble counter.
module idexe_pipe_hz #(
  parameter int ARQ        = 16,
  parameter int JADDR_W    = 13,
  parameter int ALU_OP_W   = 2,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  idexe_pipe_hz_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_en;
    logic                  mux_exe;
    logic                  jop_lsb;
    logic [ARQ-1:0]        src1;
    logic [ARQ-1:0]        src2;
    logic [ARQ-1:0]        srcdest;
    logic [ARQ-1:0]        imm;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [JADDR_W-1:0]    jaddr;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  stage_t           stage_q, stage_d, stage_in;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             load_in_exe, hazard;

  always_comb begin
    stage_in.valid   = bus.valid_in;
    stage_in.wb_en   = bus.wb_enable_in;
    stage_in.mem_en  = bus.mem_enable_in;
    stage_in.mux_exe = bus.mux_exe_in;
    stage_in.jop_lsb = bus.jop_lsb_in;
    stage_in.src1    = bus.src1_in;
    stage_in.src2    = bus.src2_in;
    stage_in.srcdest = bus.srcdest_in;
    stage_in.imm     = bus.imm_in;
    stage_in.alu_op  = bus.alu_op_in;
    stage_in.jaddr   = bus.jaddr_in;
    stage_in.rd      = bus.rd_addr_in;
  end

  // A valid load sits in EXE; its result is not ready for the instruction in ID.
  assign load_in_exe = stage_q.valid & stage_q.mem_en & stage_q.wb_en;
  assign hazard = bus.valid_in & load_in_exe & (stage_q.rd != '0) &
                  ((stage_q.rd == bus.rs1_addr_in) | (stage_q.rd == bus.rs2_addr_in)) &
                  ~bus.flush_in;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (bus.flush_in || (!bus.stall_in && hazard)) begin
      stage_d = '0;
      cnt_d   = cnt_inc;
    end else if (!bus.stall_in) begin
      stage_d = stage_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_out      = stage_q.valid;
  assign bus.wb_enable_out  = stage_q.wb_en;
  assign bus.mem_enable_out = stage_q.mem_en;
  assign bus.mux_exe_out    = stage_q.mux_exe;
  assign bus.jop_lsb_out    = stage_q.jop_lsb;
  assign bus.src1_out       = stage_q.src1;
  assign bus.src2_out       = stage_q.src2;
  assign bus.srcdest_out    = stage_q.srcdest;
  assign bus.imm_out        = stage_q.imm;
  assign bus.alu_op_out     = stage_q.alu_op;
  assign bus.jaddr_out      = stage_q.jaddr;
  assign bus.rd_addr_out    = stage_q.rd;
  assign bus.hazard_out     = hazard;
  assign bus.bubble_cnt_out = cnt_q;

endmodule

// File: doc/idexe_pipe_hz.md
Name: idexe_pipe_hz

Overview:
Parametrised next-generation ID/EXE pipeline register. It carries decoded operands and control bits from decode to execute, as the current ID/EXE stage does. It adds a valid bit, downstream stall (hold), branch flush (bubble insertion), built-in load-use hazard detection with automatic bubble insertion, and a saturating bubble counter for performance monitoring.

Parameters:
ARQ, 16, datapath width of src1/src2/srcdest/imm
JADDR_W, 13, jump address width
ALU_OP_W, 2, ALU opcode width
REG_ADDR_W, 4, register-file address width
CNT_W, 8, bubble counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_in  in  1  hold stage contents (downstream not ready)
flush_in  in  1  discard incoming instruction, insert bubble
valid_in  in  1  incoming instruction valid
wb_enable_in, mem_enable_in, mux_exe_in, jop_lsb_in  in  1 each  control bits
src1_in, src2_in, srcdest_in, imm_in  in  ARQ each  operands
alu_op_in  in  ALU_OP_W  ALU opcode
jaddr_in  in  JADDR_W  jump address
rs1_addr_in, rs2_addr_in, rd_addr_in  in  REG_ADDR_W each  register addresses
valid_out  out  1  registered valid
wb_enable_out, mem_enable_out, mux_exe_out, jop_lsb_out  out  1 each  registered controls
src1_out, src2_out, srcdest_out, imm_out  out  ARQ each  registered operands
alu_op_out  out  ALU_OP_W  registered opcode
jaddr_out  out  JADDR_W  registered jump address
rd_addr_out  out  REG_ADDR_W  registered destination address
hazard_out  out  1  combinational load-use hazard; upstream must hold IF/ID
bubble_cnt_out  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst=1 at edge): every registered output = 0, bubble_cnt_out = 0. Reset overrides all other inputs, including mid-stall and mid-hazard.
- load_in_exe = valid_out & mem_enable_out & wb_enable_out.
- hazard_out = valid_in & load_in_exe & (rd_addr_out != 0) & ((rd_addr_out == rs1_addr_in) | (rd_addr_out == rs2_addr_in)) & ~flush_in. Combinational, no latency.
- Per-edge priority, highest first:
  1. rst: clear everything.
  2. flush_in=1: load bubble. Flush wins over a simultaneous stall_in.
  3. stall_in=1: all registers hold, counter holds.
  4. hazard_out=1: load bubble.
  5. Otherwise: load all *_in fields into the *_out registers. valid_out = valid_in.
- Bubble load: valid_out=0, all control bits 0, alu_op_out=0, all data/address fields 0. bubble_cnt_out increments by 1 and saturates at 2^CNT_W-1, with no wrap.
- The counter increments only on priority-2 and priority-4 bubbles. An invalid instruction passing normally (valid_in=0) is not counted.
- Latency: 1 cycle from input to output on normal load.
- A hazard resolves itself: after the bubble, load_in_exe=0, so hazard_out drops and the held instruction loads on the next edge. Exactly one bubble is inserted per load-use pair.
- rd_addr_out=0 never raises a hazard (register 0 is hard-wired).
- While valid_in=0, hazard_out=0.

Test Plan:
1. Reset then normal load: rst high for 10 cycles, then valid_in=1, wb_enable_in=1, mux_exe_in=1, src1_in=152, src2_in=155, srcdest_in=170, imm_in=450, alu_op_in=0, jaddr_in=1254. While in reset, all outputs are 0. One edge later the outputs equal the inputs, valid_out=1, bubble_cnt_out=0.
2. Stall: load the case-1 instruction, then assert stall_in for 3 cycles while changing src1_in to 999. Outputs hold 152 for those 3 cycles. src1_out=999 one edge after stall_in drops. Counter stays 0.
3. Flush plus stall: with valid content loaded, assert flush_in=1 and stall_in=1 together. Next edge gives valid_out=0, all fields 0, bubble_cnt_out=1.
4. Load-use hazard: load an instruction with mem_enable=1, wb_enable=1, rd_addr=5. Then present valid_in=1, rs2_addr_in=5. hazard_out=1 in the same cycle, the next edge inserts a bubble (count +1), hazard_out then falls to 0, and the consumer loads on the following edge. Repeat with rd_addr=0: no hazard.
5. Non-load dependency: producer with mem_enable=0, rd_addr=5, consumer rs1_addr_in=5. hazard_out=0 and no bubble is inserted.
6. Counter saturation (CNT_W=2): apply 5 consecutive flushes. bubble_cnt_out reads 1, 2, 3, 3, 3. A subsequent rst returns it to 0.
